// File: rtl/mmio_uart_tx.sv
// Memory-mapped transmit-only 8N1 UART with a TX FIFO on the CPU data bus.
// Define UART_TX_IRQ_EN to add the CTRL register at 0xC and the registered irq output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        store,
    input  logic        load,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        hit,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic [15:0] baud_q;
    logic [15:0] reload;
    logic        tx_q;
    logic        overflow_q;
    logic [15:0] divisor_q;

    logic        full;
    logic        empty;
    logic        busy;
    logic        wr_en;
    logic        push;
    logic        pop;
    logic [1:0]  reg_sel;
    logic        unused_bits;

    assign hit     = address[31:4] == BASE_ADDR[31:4];
    assign reg_sel = address[3:2];
    assign wr_en   = store & hit;
    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign busy    = state_q != StIdle;
    // Full is sampled before any same-cycle pop, so a push while full is always dropped.
    assign push    = wr_en && (reg_sel == 2'd0) && !full;
    assign pop     = (state_q == StIdle) && !empty;
    assign reload  = divisor_q - 16'd1;
    assign tx      = tx_q;

    assign unused_bits = ^{load, address[1:0], store_data[31:16]};

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= store_data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= DIV_RESET;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            if (wr_en && (reg_sel == 2'd0) && full) begin
                overflow_q <= 1'b1;
            end else if (wr_en && (reg_sel == 2'd1) && store_data[3]) begin
                overflow_q <= 1'b0;
            end
            if (wr_en && (reg_sel == 2'd2)) begin
                divisor_q <= (store_data[15:0] == 16'd0) ? 16'd1 : store_data[15:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        shift_q <= mem_q[rptr_q[AW-1:0]];
                        baud_q  <= reload;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_q == 16'd0) begin
                        baud_q    <= reload;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= 3'd0;
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                StData: begin
                    if (baud_q == 16'd0) begin
                        baud_q <= reload;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                StStop: begin
                    if (baud_q == 16'd0) begin
                        state_q <= StIdle;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == 2'd3)) begin
                irq_en_q <= store_data[0];
            end
            irq_q <= irq_en_q & empty & ~busy;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        load_data = '0;
        if (hit) begin
            unique case (reg_sel)
                2'd0: load_data = '0;
                2'd1: load_data = {28'd0, overflow_q, busy, empty, full};
                2'd2: load_data = {16'd0, divisor_q};
`ifdef UART_TX_IRQ_EN
                2'd3: load_data = {31'd0, irq_en_q};
`else
                2'd3: load_data = '0;
`endif
                default: load_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frames are predicted as per-clock line levels
// built from the 8N1 rules (start, 8 LSB-first data, stop, one idle clock).
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] DIVR  = 16'd868;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        store = 1'b0;
    logic        load = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic [31:0] load_data;
    logic        hit;
    logic        tx;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .DIV_RESET (DIVR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .store     (store),
        .load      (load),
        .address   (address),
        .store_data(store_data),
        .load_data (load_data),
        .hit       (hit),
        .tx        (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        store = 1'b1;
        address = a;
        store_data = d;
        @(posedge clock);
        #1;
        store = 1'b0;
        address = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clock);
        load = 1'b1;
        address = a;
        #1;
        d = load_data;
        h = hit;
        load = 1'b0;
        address = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        h;
        logic [31:0] a;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: tx=%b expected 1", tx);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus_read(BASE + 32'h4, rd, h);
        checks++;
        if (rd !== 32'h2 || h !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h hit=%b expected 00000002 hit=1", rd, h);
        end
        bus_read(BASE + 32'h8, rd, h);
        checks++;
        if (rd !== {16'h0, DIVR}) begin
            errors++;
            $display("FAIL reset_divisor: got %h expected %h", rd, {16'h0, DIVR});
        end
        bus_read(BASE, rd, h);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h expected 0", rd);
        end
        bus_read(BASE + 32'hC, rd, h);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reg_c_reset: got %h expected 0", rd);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
            bus_read(a, rd, h);
            checks++;
            if (h !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL miss_read: addr=%h hit=%b data=%h expected hit=0 data=0", a, h, rd);
            end
        end
    endtask

    task automatic test_frames(input logic [15:0] d, input int n,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0]  bytes [3];
        logic        q[$];
        logic        bitv;
        logic        e;
        logic [31:0] rd;
        logic        h;
        int          idx;
        bytes = '{b0, b1, b2};
        bus_write(BASE + 32'h8, {16'h0, d});
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0) bitv = 1'b0;
                else if (k == 9) bitv = 1'b1;
                else bitv = bytes[i][k-1];
                repeat (int'(d)) q.push_back(bitv);
            end
            q.push_back(1'b1);
        end
        idx = 0;
        fork
            begin
                for (int i = 0; i < n; i++) bus_write(BASE, {24'h0, bytes[i]});
            end
            begin
                @(negedge clock);
                @(posedge clock);
                #2;
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_latency: tx=%b expected 1 on the store edge", tx);
                end
                while (q.size() > 0) begin
                    @(posedge clock);
                    #2;
                    e = q.pop_front();
                    checks++;
                    if (tx !== e) begin
                        errors++;
                        $display("FAIL frame_line: div=%0d sample %0d tx=%b expected %b",
                                 d, idx, tx, e);
                    end
                    idx++;
                end
            end
        join
        bus_read(BASE + 32'h4, rd, h);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL frames_end_status: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        logic        h;
        logic [31:0] v;
        logic [31:0] expv;
        @(negedge clock);
        store = 1'b1;
        address = BASE + 32'h10;
        store_data = 32'h77;
        #1;
        checks++;
        if (hit !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL miss_store: hit=%b data=%h expected hit=0 data=0", hit, load_data);
        end
        @(posedge clock);
        #1;
        store = 1'b0;
        address = '0;
        bus_read(BASE + 32'h4, rd, h);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL miss_no_push: status=%h expected 00000002", rd);
        end
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL miss_tx_idle: tx=%b expected 1", tx);
            end
        end
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            expv = {16'h0, (v[15:0] == 16'h0) ? 16'h1 : v[15:0]};
            bus_write(BASE + 32'h8, v);
            bus_read(BASE + 32'h8 + 32'(i), rd, h);
            checks++;
            if (rd !== expv || h !== 1'b1) begin
                errors++;
                $display("FAIL divisor_rw: got %h hit=%b expected %h hit=1", rd, h, expv);
            end
        end
        bus_write(BASE + 32'h8, 32'hFFFF_0000);
        bus_read(BASE + 32'h8, rd, h);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL divisor_zero: got %h expected 00000001", rd);
        end
`ifndef UART_TX_IRQ_EN
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, rd, h);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reserved_write: got %h expected 0", rd);
        end
`endif
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes [DEPTH+2];
        logic        q[$];
        logic        bitv;
        logic        e;
        logic [31:0] rd;
        logic        h;
        int          idx;
        for (int i = 0; i < DEPTH + 2; i++) bytes[i] = 8'($urandom);
        bus_write(BASE + 32'h8, 32'd100);
        // The first byte leaves for the shifter; only DEPTH more fit, the last is dropped.
        for (int i = 0; i < DEPTH + 1; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0) bitv = 1'b0;
                else if (k == 9) bitv = 1'b1;
                else bitv = bytes[i][k-1];
                repeat (100) q.push_back(bitv);
            end
            q.push_back(1'b1);
        end
        idx = 0;
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) bus_write(BASE, {24'h0, bytes[i]});
                bus_read(BASE + 32'h4, rd, h);
                checks++;
                if (rd !== 32'hD) begin
                    errors++;
                    $display("FAIL overflow_set: status=%h expected 0000000d", rd);
                end
                bus_write(BASE + 32'h4, 32'h7);
                bus_read(BASE + 32'h4, rd, h);
                checks++;
                if (rd !== 32'hD) begin
                    errors++;
                    $display("FAIL overflow_keep: status=%h expected 0000000d", rd);
                end
                bus_write(BASE + 32'h4, 32'h8);
                bus_read(BASE + 32'h4, rd, h);
                checks++;
                if (rd !== 32'h5) begin
                    errors++;
                    $display("FAIL overflow_clear: status=%h expected 00000005", rd);
                end
            end
            begin
                @(negedge clock);
                @(posedge clock);
                while (q.size() > 0) begin
                    @(posedge clock);
                    #2;
                    e = q.pop_front();
                    checks++;
                    if (tx !== e) begin
                        errors++;
                        $display("FAIL overflow_line: sample %0d tx=%b expected %b", idx, tx, e);
                    end
                    idx++;
                end
            end
        join
        bus_read(BASE + 32'h4, rd, h);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL overflow_drained: status=%h expected 00000002", rd);
        end
    endtask

`ifdef UART_TX_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        logic        h;
        bus_write(BASE + 32'h8, 32'd2);
        bus_write(BASE + 32'hC, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: irq=%b expected 0", irq);
        end
        @(posedge clock);
        #2;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_enable: irq=%b expected 1", irq);
        end
        bus_read(BASE + 32'hC, rd, h);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_read: got %h expected 00000001", rd);
        end
        bus_write(BASE, {24'h0, 8'($urandom)});
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_push_edge: irq=%b expected 1", irq);
        end
        for (int k = 0; k < 21; k++) begin
            @(posedge clock);
            #2;
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL irq_busy: clock %0d irq=%b expected 0", k, irq);
            end
        end
        @(posedge clock);
        #2;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_return: irq=%b expected 1", irq);
        end
        bus_write(BASE + 32'hC, 32'h0);
        @(posedge clock);
        #2;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_disable: irq=%b expected 0", irq);
        end
    endtask
`endif

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic        h;
        bus_write(BASE + 32'h8, 32'd8);
        for (int i = 0; i < 3; i++) bus_write(BASE, 32'h0);
        repeat (28) @(posedge clock);
        @(negedge clock);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL midframe_low: tx=%b expected 0", tx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_tx: tx=%b expected 1", tx);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus_read(BASE + 32'h4, rd, h);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL midframe_status: got %h expected 00000002", rd);
        end
        bus_read(BASE + 32'h8, rd, h);
        checks++;
        if (rd !== {16'h0, DIVR}) begin
            errors++;
            $display("FAIL midframe_divisor: got %h expected %h", rd, {16'h0, DIVR});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL midframe_flushed: clock %0d tx=%b expected 1", k, tx);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frames(16'd4, 1, 8'h55, 8'h00, 8'h00);
        test_frames(16'd2, 2, 8'hA5, 8'h3C, 8'h00);
        for (int r = 0; r < 4; r++) begin
            test_frames(16'($urandom_range(5, 2)), int'($urandom_range(3, 1)),
                        8'($urandom), 8'($urandom), 8'($urandom));
        end
        test_decode();
        test_overflow();
`ifdef UART_TX_IRQ_EN
        test_irq();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
